// File: rtl/clk_div_multi_pkg.sv
// rtl/clk_div_multi_pkg.sv - shared constants and helpers for the multi-channel clock divider
// Contents: DIV_W_DEF (default divisor width), N_CH_MAX (channel limit),
//           ch_idx_w() (channel index width, min 1), eff_half() (divisor 0 acts as 1).
package clk_div_pkg;

    localparam int DIV_W_DEF = 32;
    localparam int N_CH_MAX  = 16;

    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic logic [DIV_W_DEF-1:0] eff_half(input logic [DIV_W_DEF-1:0] div);
        return (div == '0) ? DIV_W_DEF'(1) : div;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - enable, divisor-write and output bundle of the clock divider
// Signals: en[N_CH] per-channel enable; wr_en/wr_ch/wr_div divisor write strobe;
//          clk_out[N_CH] divided clocks; tick[N_CH] toggle pulses; pend[N_CH] divisor pending.
// Modports: master drives enables/writes, slave (the divider) drives the outputs.
interface clk_div_multi_if #(
    parameter int N_CH  = 4,
    parameter int DIV_W = clk_div_pkg::DIV_W_DEF
);
    import clk_div_pkg::*;

    localparam int CH_IDX_W = ch_idx_w(N_CH);

    logic [N_CH-1:0]     en;
    logic                wr_en;
    logic [CH_IDX_W-1:0] wr_ch;
    logic [DIV_W-1:0]    wr_div;
    logic [N_CH-1:0]     clk_out;
    logic [N_CH-1:0]     tick;
    logic [N_CH-1:0]     pend;

    modport master (
        output en, wr_en, wr_ch, wr_div,
        input  clk_out, tick, pend
    );

    modport slave (
        input  en, wr_en, wr_ch, wr_div,
        output clk_out, tick, pend
    );

endinterface

// File: rtl/clk_div_multi_chan.sv
// rtl/clk_div_multi_chan.sv - one divider channel: counter, active/pending divisor, toggle and tick
// Ports: CCLK clock; RSTN async active-low reset; en channel enable; ld divisor write strobe;
//        ld_val written divisor; sync phase restart; clk_out square wave; tick toggle pulse;
//        pend written divisor waiting for the next toggle.
// DIV_W may be at most 32: the terminal-count compare is done at the package width.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             CCLK,
    input  logic             RSTN,
    input  logic             en,
    input  logic             ld,
    input  logic [DIV_W-1:0] ld_val,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    logic [DIV_W-1:0]     cnt;
    logic [DIV_W-1:0]     div_act;
    logic [DIV_W-1:0]     div_pend;
    logic [DIV_W_DEF-1:0] half_m1;
    logic                 term;

    // The divisor only changes when cnt returns to 0, so cnt can never sit
    // above half_m1 and an equality compare is sufficient.
    assign half_m1 = eff_half(DIV_W_DEF'(div_act)) - DIV_W_DEF'(1);
    assign term    = (DIV_W_DEF'(cnt) == half_m1);

    // div_pend is kept equal to div_act whenever pend is low, so a sync can
    // always copy div_pend into div_act without checking pend.
    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            pend     <= 1'b0;
            div_act  <= DIV_W'(DEFAULT_DIV);
            div_pend <= DIV_W'(DEFAULT_DIV);
        end else if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            div_act <= div_pend;
            if (ld) begin
                div_pend <= ld_val;
                pend     <= 1'b1;
            end else begin
                pend <= 1'b0;
            end
        end else if (!en) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            // An idle channel has no phase to protect: apply immediately.
            if (ld) begin
                div_act  <= ld_val;
                div_pend <= ld_val;
                pend     <= 1'b0;
            end
        end else if (term) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
            if (ld) begin
                div_act  <= ld_val;
                div_pend <= ld_val;
                pend     <= 1'b0;
            end else if (pend) begin
                div_act <= div_pend;
                pend    <= 1'b0;
            end
        end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
            if (ld) begin
                div_pend <= ld_val;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - N-channel programmable clock divider / enable generator
// Ports: CCLK system clock; RSTN async active-low reset; bus (clk_div_multi_if.slave)
//        carrying en, wr_en/wr_ch/wr_div, clk_out, tick, pend; sync (CLKDIV_SYNC_EN only).
// Macro CLKDIV_SYNC_EN: adds the sync input that restarts all channels phase-aligned.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic           CCLK,
    input  logic           RSTN,
`ifdef CLKDIV_SYNC_EN
    input  logic           sync,
`endif
    clk_div_multi_if.slave bus
);

    logic [N_CH-1:0] ld;
    logic [N_CH-1:0] clk_out_w;
    logic [N_CH-1:0] tick_w;
    logic [N_CH-1:0] pend_w;
    logic            sync_i;

`ifdef CLKDIV_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    // Out-of-range channel indices match no channel and are dropped.
    always_comb begin
        ld = '0;
        for (int i = 0; i < N_CH; i++) begin
            ld[i] = bus.wr_en && (32'(bus.wr_ch) == 32'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .CCLK    (CCLK),
            .RSTN    (RSTN),
            .en      (bus.en[g]),
            .ld      (ld[g]),
            .ld_val  (bus.wr_div),
            .sync    (sync_i),
            .clk_out (clk_out_w[g]),
            .tick    (tick_w[g]),
            .pend    (pend_w[g])
        );
    end

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_w;
    assign bus.pend    = pend_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi
module tb_clk_div_multi;

    localparam int N_CH = 3;

    typedef struct {
        int ch;
        int cyc;
        bit lvl;
    } ev_t;

    logic CCLK = 1'b0;
    logic RSTN = 1'b0;
    logic sync = 1'b0;

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;

    ev_t             exp_q[$];
    logic [N_CH-1:0] watch = '0;

    clk_div_multi_if #(.N_CH(N_CH), .DIV_W(32)) bus ();

    clk_div_multi #(
        .N_CH        (N_CH),
        .DIV_W       (32),
        .DEFAULT_DIV (1)
    ) dut (
        .CCLK (CCLK),
        .RSTN (RSTN),
`ifdef CLKDIV_SYNC_EN
        .sync (sync),
`endif
        .bus  (bus)
    );

    always #5 CCLK = ~CCLK;

    always @(posedge CCLK) cyc <= cyc + 1;

    function automatic int find_ev(input int ch);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].ch == ch) return i;
        end
        return -1;
    endfunction

    // Monitor: every tick on a watched channel must match that channel's
    // oldest expected event, both in cycle and in the clk_out level.
    always @(negedge CCLK) begin
        for (int c = 0; c < N_CH; c++) begin
            if (watch[c] && bus.tick[c]) begin
                int idx;
                idx = find_ev(c);
                n_checks++;
                if (idx < 0) begin
                    n_err++;
                    $display("FAIL unexpected_tick ch%0d: tick at cyc %0d, required no tick", c, cyc);
                end else begin
                    if (exp_q[idx].cyc != cyc || bus.clk_out[c] != exp_q[idx].lvl) begin
                        n_err++;
                        $display("FAIL tick_ch%0d: got tick at cyc %0d clk_out=%0d, required cyc %0d clk_out=%0d",
                                 c, cyc, bus.clk_out[c], exp_q[idx].cyc, exp_q[idx].lvl);
                    end
                    exp_q.delete(idx);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CCLK);
            #2;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic wr(input int ch, input logic [31:0] val);
        bus.wr_en  = 1'b1;
        bus.wr_ch  = 2'(ch);
        bus.wr_div = val;
        step(1);
        bus.wr_en  = 1'b0;
    endtask

    // n toggles of one channel, every h cycles after start, first level 1.
    task automatic push_run(input int ch, input int start, input int h, input int n);
        ev_t e;
        for (int j = 1; j <= n; j++) begin
            e.ch  = ch;
            e.cyc = start + h * j;
            e.lvl = ((j % 2) == 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_ev(input int ch, input int c, input bit lvl);
        ev_t e;
        e.ch  = ch;
        e.cyc = c;
        e.lvl = lvl;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, required completion");
        $fatal(1);
    end

    initial begin
        int e;
        bus.en     = '0;
        bus.wr_en  = 1'b0;
        bus.wr_ch  = '0;
        bus.wr_div = '0;

        // Reset state
        step(2);
        check("rst_clk_out", 32'(bus.clk_out), 32'h0);
        check("rst_tick",    32'(bus.tick),    32'h0);
        check("rst_pend",    32'(bus.pend),    32'h0);
        RSTN = 1'b1;
        step(2);

        // Ratios: div 3, 0 and 5 loaded while idle
        wr(0, 3);
        wr(1, 0);
        wr(2, 5);
        check("idle_write_pend", 32'(bus.pend), 32'h0);
        e = cyc;
        bus.en = 3'b111;
        watch  = 3'b111;
        push_run(0, e, 3, 10);
        push_run(1, e, 1, 30);
        push_run(2, e, 5, 6);
        wait_until(e + 30);
        watch = '0;

        // Runtime change: div 4, write 2 while cnt=1
        bus.en = '0;
        step(1);
        wr(0, 4);
        e = cyc;
        bus.en = 3'b001;
        watch  = 3'b001;
        push_ev(0, e + 4, 1);
        push_ev(0, e + 8, 0);
        push_ev(0, e + 10, 1);
        push_ev(0, e + 12, 0);
        wait_until(e + 5);
        wr(0, 2);
        check("chg_pend_a", 32'(bus.pend[0]), 32'h1);
        step(1);
        check("chg_pend_b", 32'(bus.pend[0]), 32'h1);
        step(1);
        check("chg_pend_clr", 32'(bus.pend[0]), 32'h0);
        wait_until(e + 12);
        watch = '0;

        // Collision: write 7 on the terminal-count cycle of div 4
        bus.en = '0;
        step(1);
        wr(0, 4);
        e = cyc;
        bus.en = 3'b001;
        watch  = 3'b001;
        push_ev(0, e + 4, 1);
        push_ev(0, e + 11, 0);
        push_ev(0, e + 18, 1);
        wait_until(e + 3);
        wr(0, 7);
        check("coll_pend_a", 32'(bus.pend[0]), 32'h0);
        step(1);
        check("coll_pend_b", 32'(bus.pend[0]), 32'h0);
        wait_until(e + 18);
        watch = '0;

        // Enable hold on ch2, out-of-range write, re-enable with div 3
        bus.en = '0;
        step(1);
        wr(2, 3);
        e = cyc;
        bus.en = 3'b011;
        watch  = 3'b101;
        push_run(0, e, 7, 4);
        step(1);
        wr(3, 9);
        check("bad_idx_pend", 32'(bus.pend), 32'h0);
        for (int k = 3; k <= 20; k++) begin
            step(1);
            check("idle_ch2_clk_out", 32'(bus.clk_out[2]), 32'h0);
        end
        bus.en = 3'b111;
        push_ev(2, e + 23, 1);
        push_ev(2, e + 26, 0);
        wait_until(e + 28);
        watch = '0;

        // Async reset mid-run with clk_out[0]=1 and a pending divisor
        e = cyc;
        wait_until(e + 7);
        wr(0, 2);
        check("pre_rst_clk_out0", 32'(bus.clk_out[0]), 32'h1);
        check("pre_rst_pend0",    32'(bus.pend[0]),    32'h1);
        #1 RSTN = 1'b0;
        #1;
        check("async_rst_clk_out", 32'(bus.clk_out), 32'h0);
        check("async_rst_tick",    32'(bus.tick),    32'h0);
        check("async_rst_pend",    32'(bus.pend),    32'h0);
        bus.en = '0;
        step(2);
        RSTN = 1'b1;
        step(1);
        e = cyc;
        bus.en = 3'b001;
        watch  = 3'b001;
        push_run(0, e, 1, 6);
        wait_until(e + 6);
        watch = '0;

`ifdef CLKDIV_SYNC_EN
        // Sync: ch0 div 3 and ch1 div 5 started out of phase, then realigned
        bus.en = '0;
        step(1);
        wr(0, 3);
        wr(1, 5);
        bus.en = 3'b001;
        step(2);
        bus.en = 3'b011;
        step(7);
        e = cyc;
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("sync_clk_out", 32'(bus.clk_out[1:0]), 32'h0);
        watch = 3'b011;
        push_run(0, e + 1, 3, 15);
        push_run(1, e + 1, 5, 9);
        wait_until(e + 46);
        watch = '0;
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
